fft16_input_buffer: RTL
=======================

// Module: fft16_input_buffer
// PURPOSE
//   Frame buffer at the head of the 16-point radix-4 FFT datapath.
//   Accepts one complex sample per handshake in natural order, n = 0..15.
//   Once a full frame is held, it presents the four first-stage radix-4 butterfly
//   input groups in parallel: group g = {x[g], x[g+4], x[g+8], x[g+12]}.
//   These feed the scaled (sum>>1) adders of stage 1.
//   Non-overlapped operation: LOAD 16 samples, then DRAIN 4 groups, repeat.
// PARAMETERS
//   DATA_W  32  width of each real/imag component, signed two's complement
// PORTS
//   clk        in   1         rising-edge clock, single clock domain
//   rst        in   1         synchronous reset, active-high
//   in_valid   in   1         input sample valid
//   in_ready   out  1         buffer can accept a sample
//   in_re      in   DATA_W    sample real part
//   in_im      in   DATA_W    sample imag part
//   in_last    in   1         marks sample n=15 of the frame
//   out_valid  out  1         butterfly group valid
//   out_ready  in   1         downstream accepts group
//   out_re     out  4*DATA_W  lane k = [k*DATA_W +: DATA_W] = Re x[g+4k]
//   out_im     out  4*DATA_W  lane k = Im x[g+4k]
//   out_group  out  2         current group index g
//   out_last   out  1         high with group 3
//   frame_err  out  1         1-cycle pulse: frame dropped on in_last mismatch
// BEHAVIOUR
//   Reset (rst high at a clk edge):
//     state=LOAD, wr_cnt=0, grp=0, frame_err=0.
//     out_valid=0, in_ready=1 from the first cycle after reset.
//     Reset mid-LOAD or mid-DRAIN discards the frame; no partial output follows.
//   Data outputs:
//     out_re/out_im/out_group/out_last are forced to 0 whenever out_valid=0.
//     Sample bits are passed unmodified: no scaling, rounding or sign change.
//   LOAD state:
//     in_ready=1, out_valid=0.
//     On in_valid&&in_ready: store sample at mem[wr_cnt].
//       - in_last=1, wr_cnt=15: frame complete; next state DRAIN; wr_cnt->0.
//       - in_last=1, wr_cnt<15: drop frame, wr_cnt->0, frame_err=1 next cycle,
//         stay in LOAD.
//       - in_last=0, wr_cnt=15: drop frame, wr_cnt->0, frame_err=1 next cycle,
//         stay in LOAD.
//       - otherwise: wr_cnt++.
//     in_valid low: no change; gaps are allowed anywhere in the frame.
//   DRAIN state:
//     in_ready=0, out_valid=1; group g=grp read from mem (lanes as above).
//     First out_valid is the cycle after the 16th accepted sample.
//     On out_valid&&out_ready: grp++.
//       - At grp=3 (out_last=1): grp->0, state->LOAD; in_ready=1 the next cycle.
//     out_ready low: all outputs held stable and grp held; no timeout.
//   Timing:
//     Minimum frame period = 16 load + 4 drain = 20 cycles.
//     in_ready and out_valid are never high together.
//   frame_err is registered, high exactly one cycle, and 0 in all other cases.
// TESTING
//   1. Frame Re x[n]=n, Im x[n]=-n; in_last on n=15; out_ready=1.
//      -> out_valid the cycle after the 16th accept.
//      -> group1 re lanes {1,5,9,13}, im lanes {-1,-5,-9,-13}.
//      -> out_last only on group 3; in_ready=1 the cycle after that.
//   2. Same frame; out_ready=0 for 3 cycles while group 2 is shown.
//      -> group 2 data and out_group=2 held bit-stable; then groups 2,3 follow.
//   3. in_last asserted on sample n=7.
//      -> frame_err pulses 1 cycle; out_valid stays 0.
//      -> the next clean 16-sample frame drains correctly (per test 1).
//   4. Lanes loaded with 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 0.
//      -> values appear bit-exact in their lanes; no saturation or shift.
//   5. rst pulsed after group 1 is accepted.
//      -> out_valid=0 and in_ready=1 next cycle; the next frame drains from group 0.
//   6. in_valid toggled every other cycle over a full frame.
//      -> identical output to test 1; first out_valid after the 16th accept.

Source files
------------

// File: rtl/fft16_input_buffer.sv
// Frame buffer feeding the first radix-4 stage of a 16-point FFT: loads 16 samples
// in natural order, then presents groups {x[g], x[g+4], x[g+8], x[g+12]} for g = 0..3.
module fft16_input_buffer #(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_re,
  input  logic [DATA_W-1:0]     in_im,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DATA_W-1:0]   out_re,
  output logic [4*DATA_W-1:0]   out_im,
  output logic [1:0]            out_group,
  output logic                  out_last,
  output logic                  frame_err
);

  typedef enum logic {
    ST_LOAD  = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [3:0]        r_wr_cnt, w_wr_cnt_nxt;
  logic [1:0]        r_grp, w_grp_nxt;
  logic              r_frame_err, w_frame_err_nxt;
  logic              w_accept;
  logic [DATA_W-1:0] r_mem_re [16];
  logic [DATA_W-1:0] r_mem_im [16];

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_state_nxt     = r_state;
    w_wr_cnt_nxt    = r_wr_cnt;
    w_grp_nxt       = r_grp;
    w_frame_err_nxt = 1'b0;
    w_accept        = 1'b0;
    in_ready        = 1'b0;
    out_valid       = 1'b0;
    case (r_state)
      ST_LOAD: begin
        in_ready = 1'b1;
        w_accept = in_valid;
        if (in_valid) begin
          if (in_last && (r_wr_cnt == 4'd15)) begin
            w_state_nxt  = ST_DRAIN;
            w_wr_cnt_nxt = 4'd0;
          end else if (in_last || (r_wr_cnt == 4'd15)) begin
            // in_last and the 16th slot disagree: the frame is misaligned, drop it.
            w_wr_cnt_nxt    = 4'd0;
            w_frame_err_nxt = 1'b1;
          end else begin
            w_wr_cnt_nxt = r_wr_cnt + 4'd1;
          end
        end
      end
      ST_DRAIN: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (r_grp == 2'd3) begin
            w_grp_nxt   = 2'd0;
            w_state_nxt = ST_LOAD;
          end else begin
            w_grp_nxt = r_grp + 2'd1;
          end
        end
      end
      default: w_state_nxt = ST_LOAD;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_LOAD;
      r_wr_cnt    <= 4'd0;
      r_grp       <= 2'd0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_wr_cnt    <= w_wr_cnt_nxt;
      r_grp       <= w_grp_nxt;
      r_frame_err <= w_frame_err_nxt;
    end
  end

  // NOTE: sample storage has no reset; it is only read in DRAIN, after a full frame overwrote it.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_mem_re[r_wr_cnt] <= in_re;
      r_mem_im[r_wr_cnt] <= in_im;
    end
  end

  // Lane k of group g holds x[4k + g], i.e. memory index {k, g}.
  always_comb begin
    out_re    = '0;
    out_im    = '0;
    out_group = 2'd0;
    out_last  = 1'b0;
    if (out_valid) begin
      for (int k = 0; k < 4; k++) begin
        out_re[k*DATA_W +: DATA_W] = r_mem_re[{2'(k), r_grp}];
        out_im[k*DATA_W +: DATA_W] = r_mem_im[{2'(k), r_grp}];
      end
      out_group = r_grp;
      out_last  = (r_grp == 2'd3);
    end
  end

  assign frame_err = r_frame_err;

endmodule
